sifreleme_kontrolcu: RTL

- Iterative AES-128 encryption sequencer that time-multiplexes one combinational round datapath (Sifreleme_Modulu: SubBytes, ShiftRows, MixColumns, AddRoundKey) over rounds 1–9.
- Performs the initial AddRoundKey, expands round keys on the fly, and executes the final round (no MixColumns) locally.
- Accepts plaintext/key with a valid/ready handshake and returns ciphertext with a valid/ready handshake; sits between the host interface and the round datapath.

---
 rtl/sifreleme_kontrolcu_pkg.sv | 72 +++++++
 rtl/sifreleme_kontrolcu_if.sv | 23 ++
 rtl/anahtar_genisletme_adimi.sv | 25 ++
 rtl/sifreleme_modulu.sv | 36 +++
 rtl/sifreleme_kontrolcu.sv | 106 ++++++++++
 5 files changed

// File: rtl/sifreleme_kontrolcu_pkg.sv
// Shared AES-128 constants, lookup tables, FSM encoding and byte-level helpers
// used by the encryption sequencer, its key-step unit and the round datapath.
package sifreleme_kontrolcu_pkg;

    localparam int NB = 4;
    localparam int NK = 4;
    localparam int NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } durum_e;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Entry 0 and 11..15 are padding so the 4-bit round counter can index directly
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = SBOX[w[8*i +: 8]];
        end
        return r;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = SBOX[s[8*i +: 8]];
        end
        return r;
    endfunction

    // Byte k of the block sits at row k%4, column k/4; row r rotates left by r
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < NB; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c+row)%NB)) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sifreleme_kontrolcu_if.sv
// Host-side handshake bundle of the AES-128 sequencer: plaintext/key in, ciphertext out.
interface sifreleme_kontrolcu_if;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_text;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_text;
    logic         busy;

    modport master (
        output in_valid, in_text, in_key, out_ready,
        input  in_ready, out_valid, out_text, busy
    );

    modport slave (
        input  in_valid, in_text, in_key, out_ready,
        output in_ready, out_valid, out_text, busy
    );

endinterface

// File: rtl/anahtar_genisletme_adimi.sv
// One AES-128 key-schedule step: derives the next round key from the current one
// using RotWord, SubWord and the round constant, then the running XOR chain.
module anahtar_genisletme_adimi
    import sifreleme_kontrolcu_pkg::*;
(
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon_in,
    output logic [127:0] key_out
);

    logic [31:0] temp_word;
    logic [31:0] w_out [NK];

    assign temp_word = sub_word({key_in[23:0], key_in[31:24]}) ^ {rcon_in, 24'h000000};

    always_comb begin
        w_out[0] = key_in[127 -: 32] ^ temp_word;
        for (int i = 1; i < NK; i++) begin
            w_out[i] = key_in[127-32*i -: 32] ^ w_out[i-1];
        end
    end

    assign key_out = {w_out[0], w_out[1], w_out[2], w_out[3]};

endmodule

// File: rtl/sifreleme_modulu.sv
// Full AES middle round: SubBytes, ShiftRows, MixColumns, then AddRoundKey.
module Sifreleme_Modulu
    import sifreleme_kontrolcu_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    output logic [127:0] state_out
);

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [127:0] shifted;
    logic [127:0] mixed;

    assign shifted = shift_rows(sub_bytes(state_in));

    always_comb begin
        mixed = '0;
        for (int c = 0; c < NB; c++) begin
            mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
        end
    end

    assign state_out = mixed ^ round_key;

endmodule

// File: rtl/sifreleme_kontrolcu.sv
// Iterative AES-128 encryption sequencer: initial AddRoundKey on accept, nine
// shared middle rounds, a local final round, then a held ciphertext handshake.
module sifreleme_kontrolcu #(
    parameter int NR        = 10,
    parameter bit CLEAR_OUT = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    sifreleme_kontrolcu_if.slave bus
);

    import sifreleme_kontrolcu_pkg::*;

    if (NR != sifreleme_kontrolcu_pkg::NR) begin : g_nr_unsupported
        $error("sifreleme_kontrolcu: only NR=10 (AES-128) is supported");
    end

    durum_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] out_text_q, out_text_d;
    logic [3:0]   rc_q, rc_d;

    logic [127:0] next_key;
    logic [127:0] round_state;
    logic [127:0] final_state;

    anahtar_genisletme_adimi u_anahtar (
        .key_in  (rk_q),
        .rcon_in (RCON[rc_q]),
        .key_out (next_key)
    );

    Sifreleme_Modulu u_tur (
        .state_in  (st_q),
        .round_key (next_key),
        .state_out (round_state)
    );

    // The last round skips MixColumns, so it is built here from the shared helpers
    assign final_state = shift_rows(sub_bytes(st_q)) ^ next_key;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            st_q       <= '0;
            rk_q       <= '0;
            out_text_q <= '0;
            rc_q       <= '0;
        end else begin
            state_q    <= state_d;
            st_q       <= st_d;
            rk_q       <= rk_d;
            out_text_q <= out_text_d;
            rc_q       <= rc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        st_d       = st_q;
        rk_d       = rk_q;
        out_text_d = out_text_q;
        rc_d       = rc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    st_d    = bus.in_text ^ bus.in_key;
                    rk_d    = bus.in_key;
                    rc_d    = 4'd1;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                st_d = round_state;
                rk_d = next_key;
                rc_d = (rc_q >= 4'(NR)) ? 4'(NR) : rc_q + 4'd1;
                if (rc_q == 4'(NR - 1)) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                st_d       = final_state;
                out_text_d = final_state;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                    if (CLEAR_OUT) begin
                        out_text_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_text  = out_text_q;

endmodule
